// File: rtl/ysyx_23060077_clint_pkg.sv
// Shared AXI widths/response codes and the CLINT register map for ysyx_23060077_clint.
package ysyx_23060077_clint_pkg;

  // AXI bus shape shared by the SoC slaves
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  // CLINT register map: mtime sits at this offset from the region base
  localparam logic [15:0] MTIME_OFF = 16'hBFF8;

  function automatic logic [AXI_DATA_W-1:0] strb_merge(
    input logic [AXI_DATA_W-1:0] old_val,
    input logic [AXI_DATA_W-1:0] new_val,
    input logic [AXI_STRB_W-1:0] strb
  );
    logic [AXI_DATA_W-1:0] merged;
    for (int i = 0; i < AXI_STRB_W; i++) begin
      merged[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ysyx_23060077_clint_if.sv
// AXI4 bundle matching the CLINT's flat ports, for hooking the block into benches and fabrics.
interface ysyx_23060077_clint_if;
  import ysyx_23060077_clint_pkg::*;

  logic                  aw_ready;
  logic                  aw_valid;
  logic [AXI_ADDR_W-1:0] aw_addr;
  logic [AXI_ID_W-1:0]   aw_id;
  logic [AXI_LEN_W-1:0]  aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;

  logic                  w_ready;
  logic                  w_valid;
  logic [AXI_DATA_W-1:0] w_data;
  logic [AXI_STRB_W-1:0] w_strb;
  logic                  w_last;

  logic                  b_ready;
  logic                  b_valid;
  axi_resp_t             b_resp;
  logic [AXI_ID_W-1:0]   b_id;

  logic                  ar_ready;
  logic                  ar_valid;
  logic [AXI_ADDR_W-1:0] ar_addr;
  logic [AXI_ID_W-1:0]   ar_id;
  logic [AXI_LEN_W-1:0]  ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;

  logic                  r_ready;
  logic                  r_valid;
  axi_resp_t             r_resp;
  logic [AXI_DATA_W-1:0] r_data;
  logic                  r_last;
  logic [AXI_ID_W-1:0]   r_id;

  modport master (
    input  aw_ready, w_ready, b_valid, b_resp, b_id,
           ar_ready, r_valid, r_resp, r_data, r_last, r_id,
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
           w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready
  );

  modport slave (
    output aw_ready, w_ready, b_valid, b_resp, b_id,
           ar_ready, r_valid, r_resp, r_data, r_last, r_id,
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
           w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready
  );

endinterface

// File: rtl/ysyx_23060077_clint.sv
// CLINT timer: prescaled 64-bit mtime behind a minimal AXI4 slave with independent read/write FSMs.
// Build option: define CLINT_MTIME_WRITE_EN to let W beats to the mtime address overwrite mtime.
module ysyx_23060077_clint
  import ysyx_23060077_clint_pkg::*;
#(
  parameter logic [AXI_ADDR_W-1:0] BASE = 32'h0200_0000,
  parameter int unsigned           DIV  = 1
) (
  input  logic                  aclk,
  input  logic                  areset_n,

  output logic                  axi_aw_ready_o,
  input  logic                  axi_aw_valid_i,
  input  logic [AXI_ADDR_W-1:0] axi_aw_addr_i,
  input  logic [AXI_ID_W-1:0]   axi_aw_id_i,
  input  logic [AXI_LEN_W-1:0]  axi_aw_len_i,
  input  logic [2:0]            axi_aw_size_i,
  input  logic [1:0]            axi_aw_burst_i,

  output logic                  axi_w_ready_o,
  input  logic                  axi_w_valid_i,
  input  logic [AXI_DATA_W-1:0] axi_w_data_i,
  input  logic [AXI_STRB_W-1:0] axi_w_strb_i,
  input  logic                  axi_w_last_i,

  input  logic                  axi_b_ready_i,
  output logic                  axi_b_valid_o,
  output axi_resp_t             axi_b_resp_o,
  output logic [AXI_ID_W-1:0]   axi_b_id_o,

  output logic                  axi_ar_ready_o,
  input  logic                  axi_ar_valid_i,
  input  logic [AXI_ADDR_W-1:0] axi_ar_addr_i,
  input  logic [AXI_ID_W-1:0]   axi_ar_id_i,
  input  logic [AXI_LEN_W-1:0]  axi_ar_len_i,
  input  logic [2:0]            axi_ar_size_i,
  input  logic [1:0]            axi_ar_burst_i,

  input  logic                  axi_r_ready_i,
  output logic                  axi_r_valid_o,
  output axi_resp_t             axi_r_resp_o,
  output logic [AXI_DATA_W-1:0] axi_r_data_o,
  output logic                  axi_r_last_o,
  output logic [AXI_ID_W-1:0]   axi_r_id_o
);

  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  localparam logic [AXI_ADDR_W-1:0] MTIME_ADDR = BASE + {16'h0000, MTIME_OFF};
  localparam logic [7:0]            PRE_LAST   = 8'(DIV - 1);

  logic [7:0]            pre_q, pre_d;
  logic [AXI_DATA_W-1:0] mtime_q, mtime_d;
  logic                  tick;

  r_state_e              r_state_q, r_state_d;
  logic                  ar_fire, r_fire, r_last;
  logic [AXI_ID_W-1:0]   rid_q;
  logic [AXI_LEN_W-1:0]  rlen_q, beat_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  axi_resp_t             rresp_q;

  w_state_e              w_state_q, w_state_d;
  logic                  aw_fire, w_fire, b_fire;
  logic [AXI_ID_W-1:0]   wid_q;
  logic                  whit_q;

  // Only the 8-byte word matters; sub-word offsets all hit the same register.
  function automatic logic word_hit(input logic [AXI_ADDR_W-4:0] word);
    return word == MTIME_ADDR[AXI_ADDR_W-1:3];
  endfunction

  assign ar_fire = axi_ar_valid_i & axi_ar_ready_o;
  assign r_fire  = axi_r_valid_o  & axi_r_ready_i;
  assign r_last  = (beat_q == rlen_q);
  assign aw_fire = axi_aw_valid_i & axi_aw_ready_o;
  assign w_fire  = axi_w_valid_i  & axi_w_ready_o;
  assign b_fire  = axi_b_valid_o  & axi_b_ready_i;

  // ---------------- timebase ----------------
  assign tick = (pre_q == PRE_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pre_d   = tick ? 8'd0 : pre_q + 8'd1;
    mtime_d = mtime_q + {{(AXI_DATA_W-1){1'b0}}, tick};
`ifdef CLINT_MTIME_WRITE_EN
    if (w_fire && whit_q) begin
      mtime_d = strb_merge(mtime_q, axi_w_data_i, axi_w_strb_i);
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      pre_q   <= '0;
      mtime_q <= '0;
    end else begin
      pre_q   <= pre_d;
      mtime_q <= mtime_d;
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state_q <= R_IDLE;
    else           r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (axi_ar_valid_i)   r_state_d = R_DATA;
      R_DATA:  if (r_fire && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // NOTE: the response holding registers are reset too, so nothing is X after reset even if probed.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rid_q   <= '0;
      rlen_q  <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_fire) begin
      // mtime_q is the pre-edge value, so a same-cycle mtime write is not visible here
      rid_q   <= axi_ar_id_i;
      rlen_q  <= axi_ar_len_i;
      beat_q  <= '0;
      rdata_q <= word_hit(axi_ar_addr_i[AXI_ADDR_W-1:3]) ? mtime_q : '0;
      rresp_q <= word_hit(axi_ar_addr_i[AXI_ADDR_W-1:3]) ? RESP_OKAY : RESP_SLVERR;
    end else if (r_fire) begin
      beat_q  <= beat_q + 8'd1;
    end
  end

  always_comb begin
    axi_ar_ready_o = 1'b0;
    axi_r_valid_o  = 1'b0;
    axi_r_resp_o   = RESP_OKAY;
    axi_r_data_o   = '0;
    axi_r_last_o   = 1'b0;
    axi_r_id_o     = '0;
    case (r_state_q)
      R_IDLE: axi_ar_ready_o = 1'b1;
      R_DATA: begin
        axi_r_valid_o = 1'b1;
        axi_r_resp_o  = rresp_q;
        axi_r_data_o  = rdata_q;
        axi_r_last_o  = r_last;
        axi_r_id_o    = rid_q;
      end
      default: ;
    endcase
  end

  // ---------------- write channel ----------------
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) w_state_q <= W_IDLE;
    else           w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (axi_aw_valid_i)        w_state_d = W_DATA;
      W_DATA:  if (w_fire && axi_w_last_i) w_state_d = W_RESP;
      W_RESP:  if (b_fire)                w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wid_q  <= '0;
      whit_q <= 1'b0;
    end else if (aw_fire) begin
      wid_q  <= axi_aw_id_i;
      whit_q <= word_hit(axi_aw_addr_i[AXI_ADDR_W-1:3]);
    end
  end

  always_comb begin
    axi_aw_ready_o = 1'b0;
    axi_w_ready_o  = 1'b0;
    axi_b_valid_o  = 1'b0;
    axi_b_resp_o   = RESP_OKAY;
    axi_b_id_o     = '0;
    case (w_state_q)
      W_IDLE: axi_aw_ready_o = 1'b1;
      W_DATA: axi_w_ready_o  = 1'b1;
      W_RESP: begin
        axi_b_valid_o = 1'b1;
        axi_b_id_o    = wid_q;
`ifdef CLINT_MTIME_WRITE_EN
        axi_b_resp_o  = whit_q ? RESP_OKAY : RESP_SLVERR;
`else
        axi_b_resp_o  = RESP_SLVERR;
`endif
      end
      default: ;
    endcase
  end

  // Burst shape and sub-word address bits carry no meaning for a single 64-bit register.
  logic unused_inputs;
`ifdef CLINT_MTIME_WRITE_EN
  assign unused_inputs = ^{axi_aw_addr_i[2:0], axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i,
                           axi_ar_addr_i[2:0], axi_ar_size_i, axi_ar_burst_i};
`else
  assign unused_inputs = ^{axi_aw_addr_i[2:0], axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i,
                           axi_ar_addr_i[2:0], axi_ar_size_i, axi_ar_burst_i,
                           axi_w_data_i, axi_w_strb_i, whit_q};
`endif

endmodule
